encoder_velocity: RTL and testbench

Samples the signed quadrature position count from the pendulum encoder stage at a fixed rate. Computes the per-sample position delta with correction for the encoder's ±1000 wrap, and a moving-average velocity over the last 2^AVG_LOG2 deltas. Results go to the downstream control/display logic over a valid/ready handshake, with sticky overrun reporting.

---
 rtl/encoder_velocity.sv | 246 ++++++++++++++++++++++++
 tb/tb_encoder_velocity.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_velocity.sv
// encoder_velocity
// Samples the quadrature position count at a fixed rate. Each sample yields a
// position delta corrected for the upstream +/-COUNT_SPAN/2 wrap, plus a
// moving average over the last 2^AVG_LOG2 deltas. Results leave over a
// valid/ready handshake. An unaccepted result that gets overwritten is
// reported through a sticky overrun flag.
//
// Pipeline for a sample tick in cycle T:
//   T   : count captured into cur_r
//   T+1 : delta computed and wrap-corrected into raw_r, prev_r <= cur_r
//   T+2 : ring buffer and running sum updated, output registers loaded
//   T+3 : out_valid high with the new result
// Only one sample is ever in flight, because SAMPLE_DIV >= 4.

module encoder_velocity #(
   parameter int SAMPLE_DIV = 50000,
   parameter int COUNT_SPAN = 2000,
   parameter int AVG_LOG2   = 3
) (
   input  logic               clk,
   input  logic               synch_reset_n,
   input  logic signed [31:0] count,
   input  logic               enable,
   input  logic               out_ready,
   output logic               sample_tick,
   output logic               out_valid,
   output logic signed [31:0] vel_raw,
   output logic signed [31:0] vel_avg,
   output logic               overrun
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = 32 + AVG_LOG2;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   localparam logic [DIV_W-1:0]    DIV_ZERO  = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0]    DIV_ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0]    DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [DIV_W-1:0]    DIV_PRE   = DIV_W'(SAMPLE_DIV - 2);
   localparam logic [AVG_LOG2-1:0] PTR_ZERO  = {AVG_LOG2{1'b0}};
   localparam logic [AVG_LOG2-1:0] PTR_ONE   = AVG_LOG2'(1);
   localparam logic [AVG_LOG2-1:0] FILL_LAST = AVG_LOG2'(DEPTH - 1);
   localparam logic signed [31:0]  HALF_SPAN = 32'(COUNT_SPAN / 2);
   localparam logic signed [31:0]  SPAN      = 32'(COUNT_SPAN);
   localparam logic signed [31:0]  ZERO32    = 32'sd0;
   localparam logic signed [SUM_W-1:0] SUM_ZERO = {SUM_W{1'b0}};

   typedef enum logic [1:0] {
      ST_PRIME = 2'd0,
      ST_FILL  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   // Fold a raw count difference back into the +/-COUNT_SPAN/2 window so a
   // pass through the upstream wrap point reads as a small step.
   function automatic logic signed [31:0] wrap_correct(input logic signed [31:0] diff);
      logic signed [31:0] res;
      if (diff > HALF_SPAN) begin
         res = diff - SPAN;
      end else if (diff < -HALF_SPAN) begin
         res = diff + SPAN;
      end else begin
         res = diff;
      end
      return res;
   endfunction

   // Sign-extend a 32-bit delta to the running-sum width.
   function automatic logic signed [SUM_W-1:0] sum_ext(input logic signed [31:0] val);
      return $signed({{AVG_LOG2{val[31]}}, val});
   endfunction

   // Reset and enable-low share one clear path: both re-prime the pipeline.
   logic clear_s;

   // Sample divider
   logic [DIV_W-1:0] div_cnt_r;
   logic             tick_r;

   // Sequencer and capture stage
   state_t             state_r;
   logic [AVG_LOG2-1:0] fill_cnt_r;
   logic               s1_valid_r;
   logic               s1_delta_r;
   logic               s1_emit_r;
   logic signed [31:0] cur_r;

   // Delta stage
   logic signed [31:0] prev_r;
   logic signed [31:0] raw_r;
   logic               s2_valid_r;
   logic               s2_emit_r;
   logic signed [31:0] raw_diff_s;
   logic signed [31:0] raw_corr_s;

   // Averaging stage
   logic signed [31:0]      ring_r [DEPTH];
   logic [AVG_LOG2-1:0]     wr_ptr_r;
   logic signed [SUM_W-1:0] sum_r;
   logic signed [31:0]      oldest_s;
   logic signed [SUM_W-1:0] sum_next_s;
   logic signed [SUM_W-1:0] sum_shift_s;
   logic signed [31:0]      avg_next_s;

   // Output handshake
   logic load_s;
   logic hs_s;

   // Shared clear and the combinational datapath between pipeline registers.
   always_comb begin
      clear_s     = ~synch_reset_n | ~enable;
      raw_diff_s  = cur_r - prev_r;
      raw_corr_s  = wrap_correct(raw_diff_s);
      oldest_s    = ring_r[wr_ptr_r];
      sum_next_s  = sum_r + sum_ext(raw_r) - sum_ext(oldest_s);
      sum_shift_s = sum_next_s >>> AVG_LOG2;
      avg_next_s  = sum_shift_s[31:0];
      load_s      = s2_valid_r & s2_emit_r;
      hs_s        = out_valid & out_ready;
   end

   // Divider: count 0..SAMPLE_DIV-1 and flag the last count one cycle early so
   // the tick comes straight from a flop.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         div_cnt_r <= DIV_ZERO;
         tick_r    <= 1'b0;
      end else begin
         tick_r <= (div_cnt_r == DIV_PRE);
         if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= DIV_ZERO;
         end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
         end
      end
   end

   assign sample_tick = tick_r;

   // Sequencer: PRIME -> FILL -> RUN. It captures the count on each tick and
   // tags the sample with whether it carries a delta and whether it emits a
   // result.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         state_r    <= ST_PRIME;
         fill_cnt_r <= PTR_ZERO;
         s1_valid_r <= 1'b0;
         s1_delta_r <= 1'b0;
         s1_emit_r  <= 1'b0;
         cur_r      <= ZERO32;
      end else begin
         s1_valid_r <= tick_r;
         s1_delta_r <= 1'b0;
         s1_emit_r  <= 1'b0;
         if (tick_r) begin
            cur_r <= count;
            case (state_r)
               ST_PRIME: begin
                  // First sample only seeds prev; no delta exists yet.
                  state_r    <= ST_FILL;
                  fill_cnt_r <= PTR_ZERO;
               end
               ST_FILL: begin
                  s1_delta_r <= 1'b1;
                  if (fill_cnt_r == FILL_LAST) begin
                     // This delta completes the window, so it is the first
                     // one that yields a result.
                     state_r   <= ST_RUN;
                     s1_emit_r <= 1'b1;
                  end else begin
                     fill_cnt_r <= fill_cnt_r + PTR_ONE;
                  end
               end
               ST_RUN: begin
                  s1_delta_r <= 1'b1;
                  s1_emit_r  <= 1'b1;
               end
               default: begin
                  state_r    <= ST_PRIME;
                  fill_cnt_r <= PTR_ZERO;
               end
            endcase
         end
      end
   end

   // Delta stage: wrap-corrected difference against the previous sample.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         prev_r     <= ZERO32;
         raw_r      <= ZERO32;
         s2_valid_r <= 1'b0;
         s2_emit_r  <= 1'b0;
      end else begin
         s2_valid_r <= s1_valid_r & s1_delta_r;
         s2_emit_r  <= s1_valid_r & s1_emit_r;
         if (s1_valid_r) begin
            prev_r <= cur_r;
            if (s1_delta_r) begin
               raw_r <= raw_corr_s;
            end
         end
      end
   end

   // Averaging stage: the ring holds the last DEPTH deltas, and the running
   // sum swaps the oldest delta for the newest.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            ring_r[i] <= ZERO32;
         end
         wr_ptr_r <= PTR_ZERO;
         sum_r    <= SUM_ZERO;
      end else if (s2_valid_r) begin
         ring_r[wr_ptr_r] <= raw_r;
         wr_ptr_r         <= wr_ptr_r + PTR_ONE;
         sum_r            <= sum_next_s;
      end
   end

   // Output registers and handshake. A new result always wins. Overrun
   // records a result lost without a handshake and clears on the next
   // completed handshake.
   always_ff @(posedge clk) begin
      if (clear_s) begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         vel_raw   <= ZERO32;
         vel_avg   <= ZERO32;
      end else if (load_s) begin
         vel_raw   <= raw_r;
         vel_avg   <= avg_next_s;
         out_valid <= 1'b1;
         if (out_valid && !out_ready) begin
            overrun <= 1'b1;
         end else if (hs_s) begin
            overrun <= 1'b0;
         end
      end else if (hs_s) begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_encoder_velocity.sv
// Bench for encoder_velocity with SAMPLE_DIV=10, COUNT_SPAN=2000, AVG_LOG2=3.
// A sample-level reference model runs at every falling edge. On each tick it
// pushes the expected {raw, avg} with its due cycle. The same process tracks
// the expected valid/overrun behaviour and pops entries as the DUT shows or
// loses them. Scenario tasks add targeted inline checks.

module tb_encoder_velocity;

   localparam int SD    = 10;
   localparam int SPAN  = 2000;
   localparam int AL    = 3;
   localparam int DEPTH = 8;

   logic               clk = 1'b0;
   logic               synch_reset_n;
   logic signed [31:0] count;
   logic               enable;
   logic               out_ready;
   logic               sample_tick;
   logic               out_valid;
   logic signed [31:0] vel_raw;
   logic signed [31:0] vel_avg;
   logic               overrun;

   always #5 clk = ~clk;

   encoder_velocity #(
      .SAMPLE_DIV(SD),
      .COUNT_SPAN(SPAN),
      .AVG_LOG2(AL)
   ) dut (
      .clk(clk),
      .synch_reset_n(synch_reset_n),
      .count(count),
      .enable(enable),
      .out_ready(out_ready),
      .sample_tick(sample_tick),
      .out_valid(out_valid),
      .vel_raw(vel_raw),
      .vel_avg(vel_avg),
      .overrun(overrun)
   );

   typedef struct {
      int                 due;
      logic signed [31:0] raw;
      logic signed [31:0] avg;
   } exp_t;

   exp_t   exp_q[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   bit     mon_en  = 1'b0;

   // reference model state
   int     mdiv   = 0;
   int     mstate = 0;          // 0 prime, 1 fill, 2 run
   int     nfill  = 0;
   longint mprev  = 0;
   longint hist [DEPTH];
   int     hptr   = 0;
   bit     mv     = 1'b0;
   bit     mov    = 1'b0;

   task automatic model_sample(input logic signed [31:0] c);
      longint d, s, a;
      if (mstate == 0) begin
         mprev  = c;
         mstate = 1;
         nfill  = 0;
      end else begin
         d = longint'(c) - mprev;
         if (d > SPAN / 2) d = d - SPAN;
         else if (d < -(SPAN / 2)) d = d + SPAN;
         mprev = c;
         hist[hptr] = d;
         hptr = (hptr + 1) % DEPTH;
         s = 0;
         for (int i = 0; i < DEPTH; i++) s = s + hist[i];
         a = s >>> AL;
         nfill++;
         if (mstate == 1 && nfill == DEPTH) mstate = 2;
         if (mstate == 2) exp_q.push_back('{due: cyc + 3, raw: d[31:0], avg: a[31:0]});
      end
   endtask

   task automatic model_clear();
      mdiv = 0; mstate = 0; nfill = 0; mprev = 0; hptr = 0;
      for (int i = 0; i < DEPTH; i++) hist[i] = 0;
      exp_q.delete();
      mv = 1'b0; mov = 1'b0;
   endtask

   // scoreboard monitor: compare at the falling edge, then advance the model
   always @(negedge clk) begin
      bit ld;
      if (mon_en) begin
         n_tests++;
         if (sample_tick !== (mdiv == SD - 1)) begin
            n_fail++;
            $display("FAIL sb_tick cyc=%0d got %b want %b", cyc, sample_tick, (mdiv == SD - 1));
         end
         n_tests++;
         if (out_valid !== mv) begin
            n_fail++;
            $display("FAIL sb_valid cyc=%0d got %b want %b", cyc, out_valid, mv);
         end
         n_tests++;
         if (overrun !== mov) begin
            n_fail++;
            $display("FAIL sb_overrun cyc=%0d got %b want %b", cyc, overrun, mov);
         end
         if (mv) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_empty cyc=%0d got raw %0d want queued result", cyc, vel_raw);
            end else begin
               if (vel_raw !== exp_q[0].raw) begin
                  n_fail++;
                  $display("FAIL sb_raw cyc=%0d got %0d want %0d", cyc, vel_raw, exp_q[0].raw);
               end
               n_tests++;
               if (vel_avg !== exp_q[0].avg) begin
                  n_fail++;
                  $display("FAIL sb_avg cyc=%0d got %0d want %0d", cyc, vel_avg, exp_q[0].avg);
               end
            end
         end
         if (!synch_reset_n || !enable) begin
            model_clear();
         end else begin
            if (mdiv == SD - 1) model_sample(count);
            ld = (exp_q.size() > 0) && (exp_q[$].due == cyc + 1);
            if (ld) begin
               if (mv && !out_ready) begin
                  mov = 1'b1;
                  void'(exp_q.pop_front());
               end else if (mv && out_ready) begin
                  mov = 1'b0;
                  void'(exp_q.pop_front());
               end
               mv = 1'b1;
            end else if (mv && out_ready) begin
               mv = 1'b0;
               mov = 1'b0;
               void'(exp_q.pop_front());
            end
            mdiv = (mdiv == SD - 1) ? 0 : mdiv + 1;
         end
      end
      cyc++;
   end

   task automatic advance(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
      n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      n_tests++; if (sample_tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b want 0", sample_tick); end
      n_tests++; if (vel_raw !== 32'sd0) begin n_fail++; $display("FAIL reset_raw got %0d want 0", vel_raw); end
      n_tests++; if (vel_avg !== 32'sd0) begin n_fail++; $display("FAIL reset_avg got %0d want 0", vel_avg); end
      synch_reset_n = 1'b1;
      enable = 1'b1;
   endtask

   task automatic test_basic();
      for (int k = 0; k < 9; k++) begin
         count = 5 * k;
         advance(10);
      end
      count = 45;
      advance(1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early got %b want 0", out_valid); end
      advance(1);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_first got %b want 1", out_valid); end
      n_tests++; if (vel_raw !== 32'sd5) begin n_fail++; $display("FAIL basic_raw got %0d want 5", vel_raw); end
      n_tests++; if (vel_avg !== 32'sd5) begin n_fail++; $display("FAIL basic_avg got %0d want 5", vel_avg); end
      advance(8);
      count = 50;
      advance(1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_gap got %b want 0", out_valid); end
      advance(1);
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rate got %b want 1", out_valid); end
      advance(8);
   endtask

   task automatic test_wrap();
      count = 998;  advance(10);
      count = -997; advance(10);
      count = 998;  advance(2);
      n_tests++; if (vel_raw !== 32'sd5) begin n_fail++; $display("FAIL wrap_fwd got %0d want 5", vel_raw); end
      advance(8);
      advance(2);
      n_tests++; if (vel_raw !== -32'sd5) begin n_fail++; $display("FAIL wrap_rev got %0d want -5", vel_raw); end
      advance(8);
   endtask

   task automatic test_average();
      int c;
      int exp_avg [8];
      exp_avg = '{2, 1, 0, -1, -1, -1, -1, -1};
      c = 998;
      for (int i = 0; i < 8; i++) begin
         c = c + ((i < 4) ? 8 : 0);
         count = c;
         advance(10);
      end
      c = c - 1; count = c; advance(2);
      n_tests++; if (vel_avg !== 32'sd4) begin n_fail++; $display("FAIL avg_half got %0d want 4", vel_avg); end
      advance(8);
      for (int k = 0; k < 8; k++) begin
         if (k < 7) c = c - 1;
         count = c;
         advance(2);
         n_tests++;
         if (vel_avg !== 32'(exp_avg[k])) begin
            n_fail++;
            $display("FAIL avg_step%0d got %0d want %0d", k, vel_avg, exp_avg[k]);
         end
         advance(8);
      end
   endtask

   task automatic test_backpressure();
      int c;
      c = 2000;
      out_ready = 1'b0;
      count = c; advance(2);
      n_tests++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL bp_first got v%b o%b want v1 o0", out_valid, overrun); end
      advance(8);
      c = c + 3; count = c; advance(2);
      n_tests++; if (out_valid !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overwrite got v%b o%b want v1 o1", out_valid, overrun); end
      advance(1);
      out_ready = 1'b1;
      advance(1);
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0 || overrun !== 1'b0) begin n_fail++; $display("FAIL bp_accept got v%b o%b want v0 o0", out_valid, overrun); end
      advance(6);
      c = c + 3; count = c; advance(2);
      n_tests++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL bp_reload got v%b o%b want v1 o0", out_valid, overrun); end
      advance(8);
      c = c + 3; count = c; advance(1);
      out_ready = 1'b1;
      advance(1);
      n_tests++; if (out_valid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL bp_same_cycle got v%b o%b want v1 o0", out_valid, overrun); end
      advance(8);
   endtask

   task automatic test_reset_mid();
      count = 3000; advance(10);
      synch_reset_n = 1'b0;
      advance(1);
      synch_reset_n = 1'b1;
      n_tests++; if (out_valid !== 1'b0 || overrun !== 1'b0 || sample_tick !== 1'b0) begin n_fail++; $display("FAIL rst_mid_flags got v%b o%b t%b want 000", out_valid, overrun, sample_tick); end
      n_tests++; if (vel_raw !== 32'sd0 || vel_avg !== 32'sd0) begin n_fail++; $display("FAIL rst_mid_data got %0d/%0d want 0/0", vel_raw, vel_avg); end
      for (int k = 0; k < 9; k++) begin
         count = 3000 + 2 * k;
         advance(1);
         if (k == 0) begin
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_discard got %b want 0", out_valid); end
         end
         advance(9);
      end
      advance(1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_early got %b want 0", out_valid); end
      advance(1);
      n_tests++; if (out_valid !== 1'b1 || vel_raw !== 32'sd2) begin n_fail++; $display("FAIL rst_mid_first got v%b raw %0d want v1 raw 2", out_valid, vel_raw); end
      advance(8);
   endtask

   task automatic test_enable_gap();
      count = 100; advance(1);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         advance(1);
         n_tests++; if (sample_tick !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_quiet%0d got t%b v%b want t0 v0", i, sample_tick, out_valid); end
      end
      enable = 1'b1;
      for (int k = 0; k < 9; k++) begin
         count = 600 + 5 * k;
         advance(10);
      end
      advance(1);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early got %b want 0", out_valid); end
      advance(1);
      n_tests++; if (out_valid !== 1'b1 || vel_raw !== 32'sd5 || vel_avg !== 32'sd5) begin n_fail++; $display("FAIL gap_first got v%b %0d/%0d want v1 5/5", out_valid, vel_raw, vel_avg); end
      advance(8);
   endtask

   initial begin
      count = 32'sd0;
      enable = 1'b0;
      out_ready = 1'b1;
      synch_reset_n = 1'b0;
      advance(2);
      mon_en = 1'b1;
      test_reset();
      test_basic();
      test_wrap();
      test_average();
      test_backpressure();
      test_reset_mid();
      test_enable_gap();
      out_ready = 1'b1;
      advance(20);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
